// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding word-wide data memory responder.
// A request is taken in IDLE, optionally delayed by wait states in BUSY, and
// answered in RESP until the initiator consumes the response.
// Optional feature: define DMEM_WAIT_EN to insert WAIT_CYCLES wait states per
// access; without it BUSY and the wait counter are not built.
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);

`ifdef DMEM_WAIT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd2} state_t;
`endif

    state_t        state_q, state_d;
    logic          req_ready_q;
    logic          resp_valid_q;
    logic [31:0]   resp_rdata_q;
    logic          resp_err_q;
    logic [31:0]   mem_q [DEPTH];

    logic          access_s;
    logic          acc_we_s;
    logic [31:0]   acc_addr_s;
    logic [31:0]   acc_wdata_s;
    logic          acc_illegal_s;
    logic [AW-1:0] acc_idx_s;

`ifdef DMEM_WAIT_EN
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;

    // Capture the request fields on accept so they survive the wait states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else if (state_q == IDLE && req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Access operands: live request when answering straight from IDLE, else the captured copy.
    always_comb begin
        if (state_q == IDLE) begin
            acc_we_s    = req_we;
            acc_addr_s  = req_addr;
            acc_wdata_s = req_wdata;
        end else begin
            acc_we_s    = we_q;
            acc_addr_s  = addr_q;
            acc_wdata_s = wdata_q;
        end
    end
`else
    // Access operands: without wait states the access always completes on the accept edge.
    always_comb begin
        acc_we_s    = req_we;
        acc_addr_s  = req_addr;
        acc_wdata_s = req_wdata;
    end
`endif

    // Legality and word index of the access being completed.
    always_comb begin
        acc_illegal_s = (acc_addr_s[1:0] != 2'b00) || (acc_addr_s[31:2] >= 30'(DEPTH));
        acc_idx_s     = acc_addr_s[AW+1:2];
    end

    // Next-state logic; access_s marks the edge that enters RESP.
    always_comb begin
        state_d  = state_q;
        access_s = 1'b0;
`ifdef DMEM_WAIT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
`ifdef DMEM_WAIT_EN
                    if (WAIT_CYCLES > 0) begin
                        state_d = BUSY;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end else begin
                        state_d  = RESP;
                        access_s = 1'b1;
                    end
`else
                    state_d  = RESP;
                    access_s = 1'b1;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
`ifdef DMEM_WAIT_EN
            BUSY: begin
                if (cnt_q == 4'd1) begin
                    state_d  = RESP;
                    access_s = 1'b1;
                    cnt_d    = 4'd0;
                end else begin
                    state_d = BUSY;
                    cnt_d   = cnt_q - 4'd1;
                end
            end
`endif
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with registered handshake outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= (state_d == IDLE);
            resp_valid_q <= (state_d == RESP);
        end
    end

`ifdef DMEM_WAIT_EN
    // Wait-state counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Memory array and response payload; both change only on the edge entering RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else if (access_s) begin
            if (acc_illegal_s) begin
                resp_rdata_q <= 32'd0;
                resp_err_q   <= 1'b1;
            end else if (acc_we_s) begin
                mem_q[acc_idx_s] <= acc_wdata_s;
                resp_rdata_q     <= 32'd0;
                resp_err_q       <= 1'b0;
            end else begin
                resp_rdata_q <= mem_q[acc_idx_s];
                resp_err_q   <= 1'b0;
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scenarios plus randomized accesses, checked
// every cycle against a transaction-level memory model.
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int WAITC = 2;
`ifdef DMEM_WAIT_EN
    localparam int N = WAITC;
`else
    localparam int N = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state
    logic [31:0] mdl_mem [DEPTH];
    bit          pending = 1'b0;
    int          ready_at = 0;
    logic [31:0] exp_rdata = 32'd0;
    logic        exp_err = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Per-cycle comparison of the DUT against the model's view of the transaction.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
            chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
            chk("rst_resp_rdata", resp_rdata, 32'd0);
            chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        end else begin
            chk("req_ready", {31'd0, req_ready}, {31'd0, !pending});
            chk("resp_valid", {31'd0, resp_valid}, {31'd0, (pending && cyc >= ready_at)});
            if (pending && cyc >= ready_at) begin
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
            end
        end
    end

    // One complete access; called shortly after a rising edge with nothing in flight.
    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int hold, input bit tie, input bit keep_valid, input bit rst_mid,
                          output logic [31:0] obs_rdata, output logic obs_err, output int acc_cycle);
        bit illegal;
        illegal = (addr[1:0] != 2'b00) || (addr >= 32'(4 * DEPTH));
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = tie;
        if (illegal) begin
            exp_rdata = 32'd0;
            exp_err   = 1'b1;
        end else if (we) begin
            exp_rdata = 32'd0;
            exp_err   = 1'b0;
            mdl_mem[addr >> 2] = wdata;
        end else begin
            exp_rdata = mdl_mem[addr >> 2];
            exp_err   = 1'b0;
        end
        @(posedge clk); #2;
        acc_cycle = cyc;
        pending   = 1'b1;
        ready_at  = cyc + N;
        if (keep_valid) begin
            // A different store held on the bus; it must be ignored while busy.
            req_we    = 1'b1;
            req_addr  = 32'h0;
            req_wdata = 32'hFFFF_FFFF;
        end else begin
            req_valid = 1'b0;
        end
        if (rst_mid) begin
            rst_n      = 1'b0;
            pending    = 1'b0;
            req_valid  = 1'b0;
            resp_ready = 1'b0;
            for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'd0;
            repeat (2) @(posedge clk);
            #2;
            rst_n     = 1'b1;
            obs_rdata = 32'd0;
            obs_err   = 1'b0;
        end else begin
            while (cyc < ready_at + hold) begin
                @(posedge clk); #2;
            end
            obs_rdata  = resp_rdata;
            obs_err    = resp_err;
            resp_ready = 1'b1;
            @(posedge clk); #2;
            pending    = 1'b0;
            req_valid  = 1'b0;
            resp_ready = tie;
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          ac;
    int          acc_hist [4];

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'd0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #2;

        // Store then load the same word
        access(1'b1, 32'h10, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 1'b0, rd, er, ac);
        chk("model_mem_word4", mdl_mem[4], 32'hDEAD_BEEF);
        chk("store_rdata", rd, 32'd0);
        access(1'b0, 32'h10, 32'd0, 0, 1'b0, 1'b0, 1'b0, rd, er, ac);
        chk("load_0x10_rdata", rd, 32'hDEAD_BEEF);
        chk("load_0x10_err", {31'd0, er}, 32'd0);

        // Illegal accesses, then check nothing was written
        access(1'b0, 32'h13, 32'd0, 0, 1'b0, 1'b0, 1'b0, rd, er, ac);
        chk("misaligned_err", {31'd0, er}, 32'd1);
        chk("misaligned_rdata", rd, 32'd0);
        access(1'b0, 32'h100, 32'd0, 0, 1'b0, 1'b0, 1'b0, rd, er, ac);
        chk("out_of_range_err", {31'd0, er}, 32'd1);
        access(1'b1, 32'h102, 32'h1111_2222, 0, 1'b0, 1'b0, 1'b0, rd, er, ac);
        chk("bad_store_err", {31'd0, er}, 32'd1);
        access(1'b0, 32'h0, 32'd0, 0, 1'b0, 1'b0, 1'b0, rd, er, ac);
        chk("load_0x0_after_bad", rd, 32'd0);

        // Stalled response with a second request held on the bus
        access(1'b1, 32'h24, 32'hA5A5_5A5A, 0, 1'b0, 1'b0, 1'b0, rd, er, ac);
        access(1'b0, 32'h24, 32'd0, 5, 1'b0, 1'b1, 1'b0, rd, er, ac);
        chk("stalled_load_rdata", rd, 32'hA5A5_5A5A);
        access(1'b0, 32'h0, 32'd0, 0, 1'b0, 1'b0, 1'b0, rd, er, ac);
        chk("held_req_not_taken", rd, 32'd0);

        // Back-to-back stores with resp_ready tied high
        for (int k = 0; k < 4; k++) begin
            access(1'b1, 32'(4 * k), 32'hC0DE_0000 + 32'(k), 0, 1'b1, 1'b0, 1'b0, rd, er, ac);
            acc_hist[k] = ac;
        end
        for (int k = 1; k < 4; k++) chk("b2b_accept_spacing", 32'(acc_hist[k] - acc_hist[k-1]), 32'(N + 2));
        for (int k = 0; k < 4; k++) begin
            access(1'b0, 32'(4 * k), 32'd0, 0, 1'b1, 1'b0, 1'b0, rd, er, ac);
            chk("b2b_readback", rd, 32'hC0DE_0000 + 32'(k));
        end

        // Reset while a store is in flight
        access(1'b1, 32'h20, 32'h1234_5678, 0, 1'b0, 1'b0, 1'b1, rd, er, ac);
        @(posedge clk); #2;
        access(1'b0, 32'h20, 32'd0, 0, 1'b0, 1'b0, 1'b0, rd, er, ac);
        chk("load_after_reset", rd, 32'd0);
        access(1'b0, 32'h10, 32'd0, 0, 1'b0, 1'b0, 1'b0, rd, er, ac);
        chk("mem_cleared_by_reset", rd, 32'd0);

        // Randomized traffic
        for (int t = 0; t < 250; t++) begin
            int unsigned sel;
            logic [31:0] a;
            bit tie_r;
            int hold_r;
            sel = $urandom_range(0, 9);
            if (sel < 6)      a = {20'd0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
            else if (sel < 8) a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
            else if (sel < 9) a = 32'(4 * DEPTH) + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            else              a = {1'b1, 31'($urandom)};
            tie_r  = 1'($urandom_range(0, 1));
            hold_r = tie_r ? 0 : $urandom_range(0, 3);
            access(1'($urandom_range(0, 1)), a, $urandom, hold_r, tie_r,
                   1'($urandom_range(0, 1)), 1'b0, rd, er, ac);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
